// File: rtl/ram_param_clear_pkg.sv
// Shared definitions for the parametrised Hack-style word RAM with a post-reset clear sweep.
package ram_param_clear_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Number of words addressed by an addr_w-bit address.
  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/ram_param_clear_clear_sequencer.sv
// Clear sequencer: after reset, walks clr_ptr over every address once, asserting busy throughout.
module ram_param_clear_clear_sequencer
  import ram_param_clear_pkg::*;
#(
  parameter int unsigned ADDR_W         = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(depth(ADDR_W) - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;

  assign clr_ptr_d = clr_ptr_q + ADDR_W'(1);

  // The pointer wraps to 0 on the same edge that returns the FSM to idle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_ptr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_q <= clr_ptr_d;
      if (clr_ptr_q == LAST_ADDR) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = busy_o & ~reset_i;
  assign clr_addr_o = clr_ptr_q;

endmodule

// File: rtl/ram_param_clear.sv
// Word RAM with Hack port-A semantics, a combinational read-only port B and an optional clear sweep.
module ram_param_clear
  import ram_param_clear_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned ADDR_W         = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  input  logic [ADDR_W-1:0] address_b,
  output logic [WIDTH-1:0]  out_b,
  output logic              busy
);

  localparam int unsigned DEPTH = depth(ADDR_W);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  ram_param_clear_clear_sequencer #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_sequencer (
    .clock_i    (clock),
    .reset_i    (reset),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // During the sweep the sequencer owns the write port; user writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (busy) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_data = '0;
    end else begin
      wr_en = load & ~reset;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign out   = busy ? '0 : mem_q[address];
  assign out_b = busy ? '0 : mem_q[address_b];

endmodule

// File: tb/tb_ram_param_clear.sv
// Bench for ram_param_clear: directed clear/write cases plus a randomised run against an array model.
module tb_ram_param_clear;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] address_b;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  out_b;
  logic              busy;

  logic              b_reset;
  logic [WIDTH-1:0]  b_in;
  logic              b_load;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_out;
  logic [WIDTH-1:0]  b_out_b;
  logic              b_busy;

  ram_param_clear #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clk), .reset(reset), .in(in), .load(load), .address(address),
    .out(out), .address_b(address_b), .out_b(out_b), .busy(busy)
  );

  ram_param_clear #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b0)) dut_noclr (
    .clock(clk), .reset(b_reset), .in(b_in), .load(b_load), .address(b_addr),
    .out(b_out), .address_b(b_addr), .out_b(b_out_b), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents after any pending sweep, plus cycles of sweep remaining.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               clr_left;
  int               checks;
  int               failures;
  string            phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [ADDR_W-1:0] a);
    return (clr_left != 0) ? 32'(0) : 32'(ref_mem[a]);
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      clr_left = DEPTH;
    end else if (clr_left != 0) begin
      clr_left--;
    end else if (load) begin
      ref_mem[address] = in;
    end
  endtask

  task automatic tick(input bit do_chk);
    if (do_chk) begin
      #1;
      chk("busy", 32'(busy), 32'(clr_left != 0));
      chk("out", 32'(out), exp_rd(address));
      chk("out_b", 32'(out_b), exp_rd(address_b));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic read_all_zero();
    load = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      address   = ADDR_W'(i);
      address_b = ADDR_W'(DEPTH - 1 - i);
      tick(1'b1);
      chk("rd_out_zero", 32'(out), 32'(0));
      chk("rd_outb_zero", 32'(out_b), 32'(0));
    end
  endtask

  initial begin
    checks = 0; failures = 0; clr_left = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    reset = 1'b1; load = 1'b0; in = '0; address = '0; address_b = '0;
    b_reset = 1'b1; b_load = 1'b0; b_in = '0; b_addr = '0;
    @(negedge clk);

    // Reset held two cycles, then the full sweep with a dropped write in the middle.
    phase = "t1_reset";
    tick(1'b0);
    tick(1'b1);
    reset = 1'b0; b_reset = 1'b0;
    phase = "t1_sweep";
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) begin
        phase = "t3_drop"; load = 1'b1; address = 4'd3; in = 16'hBEEF;
        #1 chk("busy_during", 32'(busy), 32'(1));
        chk("out_forced0", 32'(out), 32'(0));
      end else begin
        phase = "t1_sweep"; load = 1'b0;
      end
      tick(1'b1);
    end
    chk("busy_done", 32'(busy), 32'(0));
    phase = "t1_read";
    read_all_zero();
    address = 4'd3;
    #1 chk("t3_addr3", 32'(out), 32'(0));

    // Write then read the same address on both ports.
    phase = "t2_write";
    address = 4'd5; address_b = 4'd5; in = 16'h1234; load = 1'b1;
    #1 chk("old_before_edge", 32'(out), 32'(0));
    tick(1'b1);
    load = 1'b0; in = 16'hFFFF;
    chk("out_new", 32'(out), 32'h1234);
    chk("outb_new", 32'(out_b), 32'h1234);
    tick(1'b1);

    phase = "t5_random";
    for (int n = 0; n < 200; n++) begin
      in        = WIDTH'($urandom);
      load      = 1'($urandom_range(0, 1));
      address   = ADDR_W'($urandom);
      address_b = ADDR_W'($urandom);
      tick(1'b1);
    end

    // Reset mid-sweep at pointer 7 restarts the full sweep.
    phase = "t4_restart";
    load = 1'b0; reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load = 1'b1; in = WIDTH'($urandom); address = ADDR_W'($urandom);
      tick(1'b1);
    end
    reset = 1'b1; load = 1'b0;
    tick(1'b1);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load = 1'b1; in = 16'hA5A5; address = ADDR_W'(i);
      #1 chk("busy_full", 32'(busy), 32'(1));
      tick(1'b1);
    end
    load = 1'b0;
    chk("busy_end", 32'(busy), 32'(0));
    read_all_zero();

    // Instance without sweep keeps its contents across reset.
    phase = "t6_noclear";
    b_addr = 4'd9; b_in = 16'h00AA; b_load = 1'b1;
    tick(1'b0);
    b_load = 1'b0; b_in = 16'h5555; b_reset = 1'b1;
    tick(1'b0);
    chk("busy_after_reset", 32'(b_busy), 32'(0));
    chk("out_kept", 32'(b_out), 32'h00AA);
    chk("outb_kept", 32'(b_out_b), 32'h00AA);
    b_reset = 1'b0;
    tick(1'b0);
    chk("busy_idle", 32'(b_busy), 32'(0));
    chk("out_after_release", 32'(b_out), 32'h00AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
